// File: rtl/multiword_addsub_sequencer.sv
// multiword_addsub_sequencer
// Computes W = 4*WORDS bit sums and differences by stepping a single 4-bit
// ripple-carry slice across the operands, one nibble per clock, LSB first.
// The carry between nibbles is held in a register.
// Subtraction is performed as A + ~B + 1. B is stored inverted and the
// carry register is preloaded with 1.
// Optional feature macro: ADDSUB_ZERO_FLAG_EN adds the Z (result-zero) output.
module multiword_addsub_sequencer #(
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               sub,
    input  logic [4*WORDS-1:0] A,
    input  logic [4*WORDS-1:0] B,
    output logic               busy,
    output logic               done,
    output logic [4*WORDS-1:0] Sum,
    output logic               Co,
    output logic               V
`ifdef ADDSUB_ZERO_FLAG_EN
    ,
    output logic               Z
`endif
);

    localparam int W  = 4 * WORDS;
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_carry;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;
    logic            r_co;
    logic            r_v;
    logic [3:0]      r_sum_nib [WORDS];
`ifdef ADDSUB_ZERO_FLAG_EN
    logic            r_z;
`endif

    logic [3:0]      w_a_nibs [WORDS];
    logic [3:0]      w_b_nibs [WORDS];
    logic [3:0]      w_a_nib;
    logic [3:0]      w_b_nib;
    logic [3:0]      w_s;
    logic [4:0]      w_c;
    logic [W-1:0]    w_sum_flat;
    logic            w_accept;
    logic            w_last;

    // A start request is honoured only while idle.
    // In the RUN state, start is ignored.
    assign w_accept = (r_state == IDLE) && start;
    assign w_last   = (r_cnt == CW'(WORDS - 1));

    // Split the latched operands into nibbles.
    // Collect the result nibbles into a flat vector.
    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_nib
            assign w_a_nibs[gi]             = r_a[4*gi +: 4];
            assign w_b_nibs[gi]             = r_b[4*gi +: 4];
            assign w_sum_flat[4*gi +: 4]    = r_sum_nib[gi];
        end
    endgenerate

    // Select the operand nibbles that the current count points at.
    always_comb begin
        w_a_nib = w_a_nibs[r_cnt];
        w_b_nib = w_b_nibs[r_cnt];
    end

    // The shared 4-bit ripple-carry slice.
    // w_c[3] is the carry into the slice MSB; it is used for overflow.
    assign w_c[0] = r_carry;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slice
            assign w_s[gi]     = w_a_nib[gi] ^ w_b_nib[gi] ^ w_c[gi];
            assign w_c[gi+1]   = (w_a_nib[gi] & w_b_nib[gi]) |
                                 (w_c[gi] & (w_a_nib[gi] ^ w_b_nib[gi]));
        end
    endgenerate

    // Result nibble registers.
    // Each register is cleared on accept.
    // Each register is written when the count reaches its own position.
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_sum
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sum_nib[gi] <= 4'h0;
                end else if (w_accept) begin
                    r_sum_nib[gi] <= 4'h0;
                end else if ((r_state == RUN) && (r_cnt == CW'(gi))) begin
                    r_sum_nib[gi] <= w_s;
                end
            end
        end
    endgenerate

    // Sequencer FSM.
    // It accepts an operation, steps through the nibbles, and publishes the flags with a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_co    <= 1'b0;
            r_v     <= 1'b0;
`ifdef ADDSUB_ZERO_FLAG_EN
            r_z     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= A;
                        r_b     <= sub ? ~B : B;
                        r_carry <= sub;
                        r_cnt   <= '0;
                        r_co    <= 1'b0;
                        r_v     <= 1'b0;
`ifdef ADDSUB_ZERO_FLAG_EN
                        r_z     <= 1'b0;
`endif
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_carry <= w_c[4];
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_co    <= w_c[4];
                        r_v     <= w_c[3] ^ w_c[4];
`ifdef ADDSUB_ZERO_FLAG_EN
                        // Lower nibbles are already final.
                        // The top nibble comes straight from the slice.
                        r_z     <= (w_s == 4'h0) && (w_sum_flat[W-5:0] == '0);
`endif
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign Sum  = w_sum_flat;
    assign Co   = r_co;
    assign V    = r_v;
`ifdef ADDSUB_ZERO_FLAG_EN
    assign Z    = r_z;
`endif

endmodule

// File: tb/tb_multiword_addsub_sequencer.sv
// Directed testbench for multiword_addsub_sequencer with WORDS=4 (16-bit operands).
// The Z checks are active only when ADDSUB_ZERO_FLAG_EN is defined.
module tb_multiword_addsub_sequencer;

    localparam int WORDS = 4;
    localparam int W     = 4 * WORDS;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] Sum;
    logic         Co;
    logic         V;
`ifdef ADDSUB_ZERO_FLAG_EN
    logic         Z;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic         co;
        logic         v;
        logic         z;
    } vec_t;

    vec_t vecs [8];

    multiword_addsub_sequencer #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Co    (Co),
        .V     (V)
`ifdef ADDSUB_ZERO_FLAG_EN
        ,
        .Z     (Z)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drives start with its operands at a negedge.
    // The task then lets the accepting edge pass.
    task automatic launch(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1;
        sub   = s;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = W'($urandom);
        B     = W'($urandom);
        sub   = 1'($urandom);
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    // Waits a bounded number of edges for done.
    // The task then checks the latency and the final result.
    task automatic wait_done(input vec_t v, input int already, input string nm);
        int  n    = already;
        bit  seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (done) seen = 1'b1;
            else chk({nm, "_busy_run"}, 32'(busy), 32'd1);
        end
        chk({nm, "_done_seen"}, 32'(seen), 32'd1);
        chk({nm, "_latency"}, 32'(n), 32'(WORDS));
        chk({nm, "_busy_done"}, 32'(busy), 32'd0);
        chk({nm, "_sum"}, 32'(Sum), 32'(v.sum));
        chk({nm, "_co"}, 32'(Co), 32'(v.co));
        chk({nm, "_v"}, 32'(V), 32'(v.v));
`ifdef ADDSUB_ZERO_FLAG_EN
        chk({nm, "_z"}, 32'(Z), 32'(v.z));
`endif
        $display("op %s sub=%0d a=%h b=%h sum=%h co=%0d v=%0d latency=%0d",
                 nm, v.s, v.a, v.b, Sum, Co, V, n);
    endtask

    vec_t tmp;

    initial begin
        // The expected results below were computed by hand.
        vecs[0] = '{1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 16'h5555, 16'h5555, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 16'h1234, 16'h2345, 16'hEEEF, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(Sum), 32'd0);
        chk("rst_co", 32'(Co), 32'd0);
        chk("rst_v", 32'(V), 32'd0);
`ifdef ADDSUB_ZERO_FLAG_EN
        chk("rst_z", 32'(Z), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors.
        // After each operation, check that done drops and that Sum is held.
        for (int i = 0; i < 8; i++) begin
            launch(vecs[i].s, vecs[i].a, vecs[i].b);
            wait_done(vecs[i], 0, $sformatf("vec%0d", i));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_done_drop", i), 32'(done), 32'd0);
            chk($sformatf("vec%0d_sum_hold", i), 32'(Sum), 32'(vecs[i].sum));
        end

        // Pulse start at cycles 2 and 3 of a run.
        // These starts must be ignored.
        launch(1'b0, 16'h1234, 16'h0FFF);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            start = 1'b1;
            sub   = 1'b1;
            A     = 16'hAAAA;
            B     = 16'h1111;
            @(posedge clk);
            #1;
            start = 1'b0;
            chk("ignored_busy", 32'(busy), 32'd1);
        end
        wait_done(vecs[0], 2, "ignore");

        // A start issued in the done cycle must be accepted.
        start = 1'b1;
        sub   = 1'b0;
        A     = 16'h7FFF;
        B     = 16'h0001;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_done_low", 32'(done), 32'd0);
        chk("b2b_sum_clear", 32'(Sum), 32'd0);
        wait_done(vecs[1], 0, "b2b");

        // Assert reset at cycle 2 of a run.
        // Reset must abort the run immediately.
        launch(1'b0, 16'h1234, 16'h0FFF);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(Sum), 32'd0);
        chk("abort_co", 32'(Co), 32'd0);
        chk("abort_v", 32'(V), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", 32'(done), 32'd0);
        end
        tmp = vecs[3];
        launch(tmp.s, tmp.a, tmp.b);
        wait_done(tmp, 0, "after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
